// File: rtl/puf_challenge_ctrl.sv
// rtl/puf_challenge_ctrl.sv - challenge sequencer and response packer for a 16-stage arbiter PUF
//
// Generates LFSR challenges and drives the race pulse with settle phases.
// Synchronises and samples the arbiter output, then majority-votes repeated
// evaluations. Packs the resulting bits MSB-first into a word returned over
// valid/ready.
//
// Build option: ARBITER_PUF_VOTE_EN
//   defined   - C_VOTES evaluations per bit, bit = majority of the samples
//   undefined - one evaluation per bit, no ones counter
//
// Ports:
//   iclk        clock
//   irst_n      asynchronous active-low reset
//   istart      start a batch (accepted only in IDLE)
//   iseed       LFSR seed, loaded on an accepted istart (zero maps to 16'h0001)
//   ochallenge  challenge to the PUF, equal to the LFSR state
//   opulse      race pulse to the PUF
//   iresponse   asynchronous arbiter output
//   obusy       high whenever the controller is not IDLE
//   oresp_word  packed response, first bit in the MSB
//   ovalid      oresp_word valid, held until iready
//   iready      consumer accepts oresp_word

module puf_challenge_ctrl #(
  parameter int C_SETTLE    = 4,
  parameter int C_VOTES     = 3,
  parameter int C_RESP_BITS = 8
) (
  input  logic                   iclk,
  input  logic                   irst_n,
  input  logic                   istart,
  input  logic [15:0]            iseed,
  output logic [15:0]            ochallenge,
  output logic                   opulse,
  input  logic                   iresponse,
  output logic                   obusy,
  output logic [C_RESP_BITS-1:0] oresp_word,
  output logic                   ovalid,
  input  logic                   iready
);

`ifdef ARBITER_PUF_VOTE_EN
  localparam int VOTES = C_VOTES;
`else
  localparam int VOTES = 1;
`endif
  localparam int VW = $clog2(C_VOTES + 1) + 1;
  localparam int PW = $clog2(C_SETTLE + 1);
  localparam int BW = $clog2(C_RESP_BITS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_FIRE,
    S_SAMPLE,
    S_DECIDE,
    S_OUT
  } state_t;

  state_t state, state_next;

  logic                   sync1, sync2;
  logic [15:0]            lfsr;
  logic [PW-1:0]          phase_cnt;
  logic [VW-1:0]          vote_cnt;
  logic [BW-1:0]          bit_cnt;
  logic [C_RESP_BITS-1:0] shreg;

  logic                   phase_done;
  logic [VW-1:0]          vote_cnt_n;
  logic                   votes_done;
  logic [BW-1:0]          bit_cnt_n;
  logic                   last_bit;
  logic                   bit_val;
  logic [15:0]            lfsr_n;
  logic [C_RESP_BITS-1:0] shreg_n;

`ifdef ARBITER_PUF_VOTE_EN
  logic [VW-1:0]          ones_cnt;
`else
  logic                   samp_bit;
`endif

  // Two-flop synchroniser for the asynchronous arbiter output
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= iresponse;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) state <= S_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    phase_done = (phase_cnt == PW'(C_SETTLE - 1));
    vote_cnt_n = vote_cnt + VW'(1);
    votes_done = (vote_cnt_n >= VW'(VOTES));
    bit_cnt_n  = bit_cnt + BW'(1);
    last_bit   = (bit_cnt_n == BW'(C_RESP_BITS));
`ifdef ARBITER_PUF_VOTE_EN
    bit_val    = (ones_cnt > VW'(VOTES / 2));
`else
    bit_val    = samp_bit;
`endif
    lfsr_n     = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    shreg_n    = (shreg << 1) | C_RESP_BITS'(bit_val);
    state_next = state;
    case (state)
      S_IDLE:   if (istart) state_next = S_APPLY;
      S_APPLY:  if (phase_done) state_next = S_FIRE;
      S_FIRE:   if (phase_done) state_next = S_SAMPLE;
      S_SAMPLE: state_next = votes_done ? S_DECIDE : S_APPLY;
      S_DECIDE: state_next = last_bit ? S_OUT : S_APPLY;
      S_OUT:    if (iready) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the
  // state register exactly.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      lfsr       <= '0;
      phase_cnt  <= '0;
      vote_cnt   <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      oresp_word <= '0;
      opulse     <= 1'b0;
      obusy      <= 1'b0;
      ovalid     <= 1'b0;
`ifdef ARBITER_PUF_VOTE_EN
      ones_cnt   <= '0;
`else
      samp_bit   <= 1'b0;
`endif
    end else begin
      opulse <= (state_next == S_FIRE);
      obusy  <= (state_next != S_IDLE);
      ovalid <= (state_next == S_OUT);
      case (state)
        S_IDLE: begin
          if (istart) begin
            lfsr       <= (iseed == 16'h0000) ? 16'h0001 : iseed;
            phase_cnt  <= '0;
            vote_cnt   <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            oresp_word <= '0;
`ifdef ARBITER_PUF_VOTE_EN
            ones_cnt   <= '0;
`endif
          end
        end
        S_APPLY, S_FIRE: begin
          phase_cnt <= phase_done ? '0 : phase_cnt + PW'(1);
        end
        S_SAMPLE: begin
          vote_cnt <= vote_cnt_n;
`ifdef ARBITER_PUF_VOTE_EN
          ones_cnt <= ones_cnt + VW'(sync2);
`else
          samp_bit <= sync2;
`endif
        end
        S_DECIDE: begin
          shreg    <= shreg_n;
          vote_cnt <= '0;
          bit_cnt  <= bit_cnt_n;
`ifdef ARBITER_PUF_VOTE_EN
          ones_cnt <= '0;
`endif
          // The challenge only moves when another evaluation follows, so it
          // never changes under a pulse or while the word is being offered.
          if (last_bit) oresp_word <= shreg_n;
          else          lfsr       <= lfsr_n;
        end
        default: ;
      endcase
    end
  end

  assign ochallenge = lfsr;

endmodule

// File: tb/tb_puf_challenge_ctrl.sv
// tb/tb_puf_challenge_ctrl.sv - directed bench for puf_challenge_ctrl
module tb_puf_challenge_ctrl;

`ifdef ARBITER_PUF_VOTE_EN
  localparam int NV  = 3;
  localparam int LAT = 225;
  localparam bit VOTE_MODE = 1'b1;
`else
  localparam int NV  = 1;
  localparam int LAT = 81;
  localparam bit VOTE_MODE = 1'b0;
`endif

  logic        iclk = 1'b0;
  logic        irst_n;
  logic        istart;
  logic [15:0] iseed;
  logic [15:0] ochallenge;
  logic        opulse;
  logic        iresponse;
  logic        obusy;
  logic [7:0]  oresp_word;
  logic        ovalid;
  logic        iready;

  always #5 iclk = ~iclk;

  puf_challenge_ctrl #(
    .C_SETTLE(4),
    .C_VOTES(3),
    .C_RESP_BITS(8)
  ) dut (
    .iclk(iclk),
    .irst_n(irst_n),
    .istart(istart),
    .iseed(iseed),
    .ochallenge(ochallenge),
    .opulse(opulse),
    .iresponse(iresponse),
    .obusy(obusy),
    .oresp_word(oresp_word),
    .ovalid(ovalid),
    .iready(iready)
  );

  typedef struct {
    logic [15:0] seed;
    logic [23:0] pat;          // per-evaluation response, MSB first
    logic [7:0]  word_vote;    // expected word with voting
    logic [7:0]  word_single;  // expected word with one evaluation per bit
    logic [15:0] ch0;
    logic [15:0] ch1;
  } vec_t;

  vec_t vecs[4];
  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_challenge"}, 32'(ochallenge), 32'h0);
    chk({tag, "_pulse"}, 32'(opulse), 32'h0);
    chk({tag, "_busy"}, 32'(obusy), 32'h0);
    chk({tag, "_valid"}, 32'(ovalid), 32'h0);
    chk({tag, "_word"}, 32'(oresp_word), 32'h0);
  endtask

  // Starts a batch, feeds one pattern bit per pulse and checks latency,
  // busy, challenges and the word. With do_hs=0 it returns holding OUT.
  task automatic run_vec(input vec_t v, input bit do_hs);
    int n;
    int ev;
    logic prev;
    logic busy_bad;
    logic [15:0] c0;
    logic [15:0] c1;
    logic [7:0] expw;
    expw = VOTE_MODE ? v.word_vote : v.word_single;
    @(negedge iclk);
    iseed = v.seed;
    istart = 1'b1;
    n = 0;
    ev = 0;
    prev = 1'b0;
    busy_bad = 1'b0;
    c0 = 16'h0;
    c1 = 16'h0;
    while (n < 400) begin
      @(negedge iclk);
      n++;
      istart = 1'b0;
      if (opulse && !prev) begin
        if (ev == 0) c0 = ochallenge;
        if (ev == NV) c1 = ochallenge;
        if (ev < 24) iresponse = v.pat[23 - ev];
        ev++;
      end
      prev = opulse;
      if (!obusy) busy_bad = 1'b1;
      if (ovalid) break;
    end
    chk("latency", 32'(n), 32'(LAT));
    chk("busy_throughout", 32'(busy_bad), 32'h0);
    chk("word", 32'(oresp_word), 32'(expw));
    chk("challenge_bit0", 32'(c0), 32'(v.ch0));
    chk("challenge_bit1", 32'(c1), 32'(v.ch1));
    if (do_hs) begin
      iready = 1'b1;
      @(posedge iclk);
      #1;
      chk("hs_valid_drop", 32'(ovalid), 32'h0);
      chk("hs_idle", 32'(obusy), 32'h0);
      chk("hs_word_hold", 32'(oresp_word), 32'(expw));
      iready = 1'b0;
    end
  endtask

  initial begin
    irst_n = 1'b0;
    istart = 1'b0;
    iready = 1'b0;
    iresponse = 1'b0;
    iseed = 16'h0;

    vecs[0] = '{seed: 16'hACE1, pat: 24'hFFFFFF, word_vote: 8'hFF, word_single: 8'hFF,
                ch0: 16'hACE1, ch1: 16'h59C3};
    vecs[1] = '{seed: 16'h0000, pat: 24'h000000, word_vote: 8'h00, word_single: 8'h00,
                ch0: 16'h0001, ch1: 16'h0002};
    vecs[2] = '{seed: 16'h1234, pat: 24'hA69A69, word_vote: 8'hAA, word_single: 8'hA6,
                ch0: 16'h1234, ch1: 16'h2469};
    vecs[3] = '{seed: 16'hFFFF, pat: 24'hCC78AB, word_vote: 8'hD3, word_single: 8'hCC,
                ch0: 16'hFFFF, ch1: 16'hFFFE};

    repeat (3) @(negedge iclk);
    chk_reset_outputs("reset");
    irst_n = 1'b1;

    for (int i = 0; i < 4; i++) run_vec(vecs[i], 1'b1);

    // Backpressure: word and valid hold, istart in OUT is ignored
    run_vec(vecs[0], 1'b0);
    for (int c = 0; c < 10; c++) begin
      @(negedge iclk);
      istart = (c == 4);
      chk("bp_valid", 32'(ovalid), 32'h1);
      chk("bp_word", 32'(oresp_word), 32'hFF);
    end
    istart = 1'b0;
    @(negedge iclk);
    chk("bp_still_busy", 32'(obusy), 32'h1);
    iready = 1'b1;
    @(posedge iclk);
    #1;
    chk("bp_release_valid", 32'(ovalid), 32'h0);
    chk("bp_release_idle", 32'(obusy), 32'h0);
    iready = 1'b0;

    // istart together with the handshake is taken one cycle later
    run_vec(vecs[0], 1'b0);
    iready = 1'b1;
    istart = 1'b1;
    @(posedge iclk);
    #1;
    chk("same_cycle_not_taken", 32'(obusy), 32'h0);
    chk("same_cycle_valid", 32'(ovalid), 32'h0);
    @(negedge iclk);
    iready = 1'b0;
    @(posedge iclk);
    #1;
    chk("next_cycle_taken", 32'(obusy), 32'h1);
    chk("start_clears_word", 32'(oresp_word), 32'h0);
    istart = 1'b0;

    // Asynchronous reset in the middle of FIRE
    for (int w = 0; w < 30 && !opulse; w++) @(negedge iclk);
    chk("fire_reached", 32'(opulse), 32'h1);
    #2;
    irst_n = 1'b0;
    #1;
    chk_reset_outputs("midfire_reset");
    repeat (2) @(negedge iclk);
    irst_n = 1'b1;
    run_vec(vecs[0], 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/puf_challenge_ctrl.md
# puf_challenge_ctrl

Sequencing controller that sits directly upstream of the 16-stage arbiter PUF and consumes its response. It generates challenges from an on-chip LFSR and drives the PUF race pulse with settle intervals. It samples the asynchronous arbiter output through a synchronizer, majority-votes repeated evaluations, and packs the resulting bits into a response word returned over a valid/ready handshake.

## Interface

Parameters:
- C_SETTLE, default 4: cycles per pulse-low and per pulse-high phase; must be ≥ 3.
- C_VOTES, default 3: evaluations per challenge; must be odd, 1–15.
- C_RESP_BITS, default 8: response bits per batch, 1–32.

Ports:
- iclk, input, 1: single clock.
- irst_n, input, 1: reset, asynchronous, active-low.
- istart, input, 1: start a batch; sampled only in IDLE.
- iseed, input, 16: LFSR seed, loaded on an accepted istart.
- ochallenge, output, 16: challenge to the PUF; registered.
- opulse, output, 1: race pulse to the PUF; registered.
- iresponse, input, 1: PUF arbiter output; asynchronous.
- obusy, output, 1: high in every state except IDLE.
- oresp_word, output, C_RESP_BITS: packed response, first bit in the MSB.
- ovalid, output, 1: oresp_word is valid.
- iready, input, 1: consumer accepts oresp_word.

## Operation

- iresponse passes through a 2-flop synchronizer. "Sampled" always means the second flop.
- LFSR: 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1.
  - Shifts left; bit0 receives b15^b13^b12^b10.
  - A zero seed is replaced with 16'h0001.
- ochallenge always equals the current LFSR value.

FSM states:
- IDLE: opulse=0. On istart:
  - load the LFSR;
  - clear the bit counter, vote counter, ones counter and shift register;
  - go to APPLY.
- APPLY: opulse=0 for C_SETTLE cycles, then go to FIRE.
- FIRE: opulse=1 for C_SETTLE cycles, then go to SAMPLE.
- SAMPLE: opulse=0.
  - Ones counter increments if the sampled response is 1; vote counter increments.
  - If vote counter < C_VOTES, go to APPLY; otherwise go to DECIDE.
- DECIDE:
  - bit = (ones > C_VOTES/2);
  - shift the register left, inserting bit at the LSB;
  - advance the LFSR once;
  - clear the vote and ones counters; increment the bit counter.
  - If bit counter == C_RESP_BITS, go to OUT; otherwise go to APPLY.
- OUT: ovalid=1 and oresp_word is driven from the shift register, both held stable until iready=1. On iready, go to IDLE next cycle with ovalid=0.

Boundary rules:
- istart while obusy=1 is ignored.
- iready outside OUT is ignored.
- istart in the same cycle as the IDLE entry from OUT is not accepted; it is accepted on the following cycle.
- Reset mid-operation: every state and output returns to its reset value immediately; no partial word is emitted.
- oresp_word holds its last value in IDLE; it is cleared only on reset or on an accepted istart.

Reset values:
- ochallenge=0, opulse=0, obusy=0, ovalid=0, oresp_word=0.
- Synchronizer flops=0, FSM=IDLE.

## Timing

- One evaluation is 2·C_SETTLE+1 cycles; one bit is C_VOTES·(2·C_SETTLE+1)+1 cycles.
- With istart accepted at edge k:
  - the FSM is in APPLY from k+1;
  - ovalid rises at k+1+C_RESP_BITS·(C_VOTES·(2·C_SETTLE+1)+1).
- ochallenge is stable for the whole of APPLY, FIRE and SAMPLE. It changes only on the DECIDE→APPLY edge, while opulse=0.
- The sampled response reflects iresponse from at least C_SETTLE−2 cycles after the opulse rise.
- The handshake transfers on the edge where ovalid=1 and iready=1.

## Configuration

- ARBITER_PUF_VOTE_EN defined: majority voting as described, using C_VOTES.
- Undefined: C_VOTES is treated as 1 and no ones counter is built. Each bit is the single sampled response. Bit time becomes 2·C_SETTLE+2 cycles.

## Test plan

Bench parameters: C_SETTLE=4, C_VOTES=3, C_RESP_BITS=8, ARBITER_PUF_VOTE_EN defined.

- Reset: assert irst_n=0 mid-FIRE -> all outputs 0 and FSM IDLE within the same cycle; after release, the first istart behaves normally.
- iresponse tied 1, iseed=16'hACE1, istart pulse -> ovalid at cycle 225 after acceptance; oresp_word=8'hFF; obusy high throughout.
- LFSR check -> ochallenge=16'hACE1 for bit 0 and 16'h59C3 for bit 1; iseed=0 -> ochallenge=16'h0001.
- Majority, driving iresponse per evaluation -> votes 1,0,1 yield bit 1; votes 0,0,1 yield bit 0; an alternating pattern of those two per bit yields 8'hAA.
- Backpressure: hold iready=0 for 10 cycles in OUT and pulse istart -> oresp_word and ovalid stable, istart ignored; iready=1 -> ovalid=0 and IDLE on the next edge.
- ARBITER_PUF_VOTE_EN undefined, iresponse=1 -> ovalid at cycle 81 after acceptance; oresp_word=8'hFF.
